// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - issue/result bundle between the EX stage and mdu_iter
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op_i;
    logic             flush;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] rd_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start, op_i, flush, d1, d2,
        input  busy, done, dz, rd_o, hi_o, lo_o
    );

    modport slave (
        input  start, op_i, flush, d1, d2,
        output busy, done, dz, rd_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - multiply/divide unit with fixed-latency multiply and radix-2 restoring divide
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;      // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0] b_r;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    logic             is_mul;
    logic             is_div;
    logic             div_signed;
    logic [WIDTH-1:0] d1_mag;
    logic [WIDTH-1:0] d2_mag;
    logic             mul_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rd;

    // Decode the issuing op and form operand magnitudes for a signed divide
    always_comb begin
        is_mul     = bus.op_i inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        is_div     = bus.op_i inside {OP_DIV, OP_DIVU};
        div_signed = (bus.op_i == OP_DIV);
        d1_mag     = (div_signed && bus.d1[WIDTH-1]) ? -bus.d1 : bus.d1;
        d2_mag     = (div_signed && bus.d2[WIDTH-1]) ? -bus.d2 : bus.d2;
    end

    // Full 2*WIDTH product of the latched operands, then plain/accumulate/subtract
    always_comb begin
        mul_signed = op_r inside {OP_MULT, OP_MADD, OP_MSUB};
        ext_a = mul_signed ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
        ext_b = mul_signed ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
        prod  = ext_a * ext_b;
        if (op_r inside {OP_MADD, OP_MADDU}) begin
            mul_res = {hi_r, lo_r} + prod;
        end else if (op_r inside {OP_MSUB, OP_MSUBU}) begin
            mul_res = {hi_r, lo_r} - prod;
        end else begin
            mul_res = prod;
        end
    end

    // One restoring step: shift in the next dividend bit and subtract if it fits
    always_comb begin
        shifted  = {rem_r, a_r[WIDTH-1]};
        borrow   = (shifted < {1'b0, b_r});
        diff     = shifted[WIDTH-1:0] - b_r;   // exact whenever no borrow
        rem_next = borrow ? shifted[WIDTH-1:0] : diff;
        quo_next = {a_r[WIDTH-2:0], ~borrow};
        quo_fix  = neg_q ? -quo_next : quo_next;
        rem_fix  = neg_r ? -rem_next : rem_next;
    end

    // HI/LO read-out for MFHI/MFLO
    always_comb begin
        rd = '0;
        if (bus.op_i == OP_MFHI) begin
            rd = hi_r;
        end else if (bus.op_i == OP_MFLO) begin
            rd = lo_r;
        end
    end

    // Control FSM: accept, iterate, commit HI/LO atomically; flush/rst cancel without commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            rem_r   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_pend <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else if (bus.flush) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_mul || is_div) begin
                            op_r   <= bus.op_i;
                            cnt    <= '0;
                            busy_r <= 1'b1;
                            rem_r  <= '0;
                            if (is_div) begin
                                state   <= S_DIV;
                                a_r     <= d1_mag;
                                b_r     <= d2_mag;
                                neg_q   <= div_signed && (bus.d1[WIDTH-1] != bus.d2[WIDTH-1]);
                                neg_r   <= div_signed && bus.d1[WIDTH-1];
                                dz_pend <= (bus.d2 == '0);
                            end else begin
                                state <= S_MUL;
                                a_r   <= bus.d1;
                                b_r   <= bus.d2;
                            end
                        end else if (bus.op_i == OP_MTHI) begin
                            hi_r <= bus.d1;
                        end else if (bus.op_i == OP_MTLO) begin
                            lo_r <= bus.d1;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        {hi_r, lo_r} <= mul_res;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt == DIV_LAST) begin
                        if (!dz_pend) begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                        dz_r   <= dz_pend;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        a_r   <= quo_next;
                        rem_r <= rem_next;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dz   = dz_r;
    assign bus.rd_o = rd;
    assign bus.hi_o = hi_r;
    assign bus.lo_o = lo_r;

endmodule
